jacaranda_stream_loader: RTL and testbench

JACARANDA_STREAM_LOADER -- requirements
Module: jacaranda_stream_loader

---
 rtl/jacaranda_pkg.sv | 48 ++++
 rtl/jacaranda_wb_timer.sv | 36 +++
 rtl/jacaranda_stream_loader.sv | 169 ++++++++++++++++
 tb/tb_jacaranda_stream_loader.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jacaranda_pkg.sv
// Shared definitions for the Jacaranda stream loader: the loader state
// encoding, frame field widths, the default frame header byte and two small
// helpers used when decoding a frame and addressing instruction memory.
package jacaranda_pkg;

   // Width of one stream byte (header, length, payload or checksum).
   localparam int BYTE_W = 8;

   // Payload counter width: LEN=0 stands for 256 bytes, which needs 9 bits.
   localparam int COUNT_W = 9;

   // Word index width: a frame never addresses more than 256 words.
   localparam int INDEX_W = 8;

   // Wishbone address and data width.
   localparam int WB_W = 32;

   // Frame header value that opens every frame.
   localparam logic [BYTE_W-1:0] DEFAULT_SYNC_BYTE = 8'hA5;

   // Loader states, in the order a well-formed frame visits them.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LEN   = 3'd1,
      ST_DATA  = 3'd2,
      ST_WRITE = 3'd3,
      ST_CHK   = 3'd4,
      ST_DONE  = 3'd5
   } loaderState_e;

   // One pending instruction-memory write, held stable for a whole bus cycle.
   typedef struct packed {
      logic [WB_W-1:0] adr;
      logic [WB_W-1:0] dat;
   } wbWrite_t;

   // Turns the LEN byte into a payload count; zero means a full 256 bytes.
   function automatic logic [COUNT_W-1:0] lenToCount(input logic [BYTE_W-1:0] lenByte);
      lenToCount = (lenByte == '0) ? 9'h100 : {1'b0, lenByte};
   endfunction

   // Byte address of instruction-memory word 'index' relative to 'base'.
   function automatic logic [WB_W-1:0] wordAddr(input logic [WB_W-1:0] base,
                                                input logic [INDEX_W-1:0] index);
      wordAddr = base + {22'b0, index, 2'b00};
   endfunction

endpackage

// File: rtl/jacaranda_wb_timer.sv
// Acknowledge watchdog for the loader's Wishbone writes. The count advances
// on every clock edge where the strobe is up and no acknowledge arrived, and
// holds at its limit so 'expired_o' stays high until the owner clears it.
// With LIMIT=N the strobe is allowed to stay up for exactly N cycles.
module jacaranda_wb_timer
   import jacaranda_pkg::*;
#(
   parameter int LIMIT = 16
) (
   input  logic wb_clk_i,
   input  logic wb_rst_n_i,
   input  logic start_i,
   input  logic clear_i,
   output logic expired_o
);

   localparam int CNT_W = $clog2(LIMIT + 1);

   logic [CNT_W-1:0] waitCount_q;

   // Expired once the strobe has been waiting through LIMIT-1 edges, so the
   // edge that ends the LIMIT-th strobe cycle is the one that gives up.
   assign expired_o = (waitCount_q >= CNT_W'(LIMIT - 1));

   // Count waiting cycles, restarting whenever no bus cycle is open.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         waitCount_q <= '0;
      end else if (clear_i) begin
         waitCount_q <= '0;
      end else if (start_i && !expired_o) begin
         waitCount_q <= waitCount_q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/jacaranda_stream_loader.sv
// Boot-time program loader. Bytes arriving from a UART receiver are parsed as
// frames of the form SYNC, LEN, LEN payload bytes, CHK (XOR of the payload).
// Every payload byte becomes one Wishbone single write to instruction memory
// at consecutive word addresses. The CPU is held in reset from the moment a
// frame header is accepted until a frame completes with a good checksum; a
// bad checksum or a write that is never acknowledged leaves the CPU held and
// raises a sticky error that the next frame header clears.
module jacaranda_stream_loader
   import jacaranda_pkg::*;
#(
   parameter logic [WB_W-1:0]   BASE_ADDR   = 32'h3000_0000,
   parameter int                ACK_TIMEOUT = 16,
   parameter logic [BYTE_W-1:0] SYNC_BYTE   = DEFAULT_SYNC_BYTE
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_n_i,
   input  logic [BYTE_W-1:0] s_data_i,
   input  logic              s_valid_i,
   output logic              s_ready_o,
   output logic              wbm_cyc_o,
   output logic              wbm_stb_o,
   output logic              wbm_we_o,
   output logic [3:0]        wbm_sel_o,
   output logic [WB_W-1:0]   wbm_adr_o,
   output logic [WB_W-1:0]   wbm_dat_o,
   input  logic              wbm_ack_i,
   output logic              cpu_reset_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o
);

   loaderState_e       state_q;
   logic [COUNT_W-1:0] byteCount_q;
   logic [INDEX_W-1:0] wordIndex_q;
   logic [BYTE_W-1:0]  runXor_q;
   wbWrite_t           busReq_q;
   logic               cyc_q;
   logic               done_q;
   logic               err_q;
   logic               cpuReset_q;
   logic               live_q;

   logic               readyState;
   logic               byteFire;
   logic               ackSeen;
   logic               timerExpired;
   logic               timeoutHit;
   logic [COUNT_W-1:0] nextIndex;

   // The stream is accepted only in the states that consume a byte, and not
   // at all until the first clock edge after reset has been released.
   assign readyState = (state_q == ST_IDLE) || (state_q == ST_LEN) ||
                       (state_q == ST_DATA) || (state_q == ST_CHK);
   assign s_ready_o  = live_q & readyState;
   assign byteFire   = s_valid_i & s_ready_o;

   // An acknowledge counts only while our own cycle is open; stray ones are
   // dropped here so the state machine never has to think about them.
   assign ackSeen    = cyc_q & wbm_ack_i;
   assign timeoutHit = cyc_q & ~wbm_ack_i & timerExpired;

   // Index of the word after the one being written, widened so a full
   // 256-byte frame can be compared against its 9-bit count.
   assign nextIndex  = {1'b0, wordIndex_q} + COUNT_W'(1);

   // Every bus signal follows the cycle flag, so the bus is idle outside a
   // write and drops at once when reset clears the flag.
   assign wbm_cyc_o   = cyc_q;
   assign wbm_stb_o   = cyc_q;
   assign wbm_we_o    = cyc_q;
   assign wbm_sel_o   = cyc_q ? 4'b0001 : 4'b0000;
   assign wbm_adr_o   = busReq_q.adr;
   assign wbm_dat_o   = busReq_q.dat;

   assign busy_o      = (state_q != ST_IDLE);
   assign done_o      = done_q;
   assign err_o       = err_q;
   assign cpu_reset_o = cpuReset_q;

   jacaranda_wb_timer #(
      .LIMIT(ACK_TIMEOUT)
   ) ackTimer (
      .wb_clk_i  (wb_clk_i),
      .wb_rst_n_i(wb_rst_n_i),
      .start_i   (cyc_q & ~wbm_ack_i),
      .clear_i   (~cyc_q),
      .expired_o (timerExpired)
   );

   // Frame parser, write sequencer and all registered status outputs.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state_q     <= ST_IDLE;
         byteCount_q <= '0;
         wordIndex_q <= '0;
         runXor_q    <= '0;
         busReq_q    <= '0;
         cyc_q       <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         cpuReset_q  <= 1'b1;
         live_q      <= 1'b0;
      end else begin
         live_q <= 1'b1;
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (byteFire && (s_data_i == SYNC_BYTE)) begin
                  err_q      <= 1'b0;
                  cpuReset_q <= 1'b1;
                  state_q    <= ST_LEN;
               end
            end
            ST_LEN: begin
               if (byteFire) begin
                  byteCount_q <= lenToCount(s_data_i);
                  wordIndex_q <= '0;
                  runXor_q    <= '0;
                  state_q     <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (byteFire) begin
                  runXor_q     <= runXor_q ^ s_data_i;
                  busReq_q.adr <= wordAddr(BASE_ADDR, wordIndex_q);
                  busReq_q.dat <= {{(WB_W-BYTE_W){1'b0}}, s_data_i};
                  cyc_q        <= 1'b1;
                  state_q      <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               if (ackSeen) begin
                  cyc_q       <= 1'b0;
                  busReq_q    <= '0;
                  wordIndex_q <= wordIndex_q + INDEX_W'(1);
                  state_q     <= (nextIndex < byteCount_q) ? ST_DATA : ST_CHK;
               end else if (timeoutHit) begin
                  cyc_q    <= 1'b0;
                  busReq_q <= '0;
                  err_q    <= 1'b1;
                  state_q  <= ST_IDLE;
               end
            end
            ST_CHK: begin
               if (byteFire) begin
                  if (s_data_i == runXor_q) begin
                     done_q     <= 1'b1;
                     cpuReset_q <= 1'b0;
                     state_q    <= ST_DONE;
                  end else begin
                     err_q   <= 1'b1;
                     state_q <= ST_IDLE;
                  end
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               cyc_q    <= 1'b0;
               busReq_q <= '0;
               state_q  <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jacaranda_stream_loader.sv
// Bench for the Jacaranda stream loader: fixed frames from a vector table,
// hand sequences for the 256-byte frame and a reset during a write, then
// random frames checked against a frame-level model of the loader.
module tb_jacaranda_stream_loader;

   localparam logic [31:0] BASE    = 32'h3000_0000;
   localparam int          TIMEOUT = 16;
   localparam logic [7:0]  SYNC    = 8'hA5;

   typedef logic [7:0] byteQ_t [$];

   typedef struct packed {
      logic [63:0] bytes;
      logic [3:0]  nBytes;
      logic [3:0]  ackDelay;
      logic        ackNever;
      logic [9:0]  expWrites;
      logic [31:0] expLastAdr;
      logic [31:0] expLastDat;
      logic [3:0]  expDone;
      logic        expErr;
      logic        expCpuRst;
   } vector_t;

   logic        clock     = 1'b0;
   logic        resetN    = 1'b0;
   logic [7:0]  s_data_i  = 8'h00;
   logic        s_valid_i = 1'b0;
   logic        s_ready_o;
   logic        wbm_cyc_o;
   logic        wbm_stb_o;
   logic        wbm_we_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_adr_o;
   logic [31:0] wbm_dat_o;
   logic        wbm_ack_i = 1'b0;
   logic        cpu_reset_o;
   logic        busy_o;
   logic        done_o;
   logic        err_o;

   int total      = 0;
   int bad        = 0;
   int doneCount  = 0;
   int protoErr   = 0;
   int stbRun     = 0;
   int lastStbRun = 0;
   int stbCycles  = 0;
   int ackDelay   = 0;
   bit ackNever   = 1'b0;
   bit ackNoise   = 1'b0;

   logic [31:0] gotAdr [$];
   logic [31:0] gotDat [$];
   logic [31:0] expAdr [$];
   logic [31:0] expDat [$];

   always #5 clock = ~clock;

   jacaranda_stream_loader #(
      .BASE_ADDR  (BASE),
      .ACK_TIMEOUT(TIMEOUT),
      .SYNC_BYTE  (SYNC)
   ) dut (
      .wb_clk_i   (clock),
      .wb_rst_n_i (resetN),
      .s_data_i   (s_data_i),
      .s_valid_i  (s_valid_i),
      .s_ready_o  (s_ready_o),
      .wbm_cyc_o  (wbm_cyc_o),
      .wbm_stb_o  (wbm_stb_o),
      .wbm_we_o   (wbm_we_o),
      .wbm_sel_o  (wbm_sel_o),
      .wbm_adr_o  (wbm_adr_o),
      .wbm_dat_o  (wbm_dat_o),
      .wbm_ack_i  (wbm_ack_i),
      .cpu_reset_o(cpu_reset_o),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .err_o      (err_o)
   );

   // Wishbone responder and bus monitor: acknowledges after ackDelay strobe
   // cycles, records every acknowledged write and counts protocol slips.
   always @(negedge clock) begin
      if (wbm_stb_o) begin
         stbCycles++;
         stbRun++;
         wbm_ack_i = !ackNever && (stbCycles > ackDelay);
         if (!wbm_cyc_o || !wbm_we_o || wbm_sel_o != 4'b0001 || !busy_o) protoErr++;
         if (wbm_ack_i) begin
            gotAdr.push_back(wbm_adr_o);
            gotDat.push_back(wbm_dat_o);
         end
      end else begin
         if (stbRun != 0) lastStbRun = stbRun;
         stbRun    = 0;
         stbCycles = 0;
         wbm_ack_i = ackNoise ? 1'($urandom_range(0, 1)) : 1'b0;
         if (wbm_cyc_o) protoErr++;
      end
      if (done_o) begin
         doneCount++;
         if (cpu_reset_o) protoErr++;
      end
   end

   // Watchdog so a stuck design still ends the run.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
      end
   endtask

   // Offers one byte from a falling edge and returns on the falling edge
   // after the rising edge that accepted it.
   task automatic sendByte(input logic [7:0] b);
      int waits = 0;
      s_data_i  = b;
      s_valid_i = 1'b1;
      while (!s_ready_o && waits < 100) begin
         @(negedge clock);
         waits++;
      end
      if (!s_ready_o) checkOutput("s_ready wait", {31'b0, s_ready_o}, 32'd1);
      @(negedge clock);
      s_valid_i = 1'b0;
   endtask

   task automatic applyStimulus(input byteQ_t s);
      foreach (s[i]) sendByte(s[i]);
   endtask

   task automatic waitIdle(input int budget);
      int n = 0;
      while (busy_o && n < budget) begin
         @(negedge clock);
         n++;
      end
      checkOutput("idle wait", {31'b0, busy_o}, 32'd0);
      @(negedge clock);
   endtask

   task automatic clearScoreboard();
      gotAdr.delete();
      gotDat.delete();
      doneCount = 0;
   endtask

   // Frame-level model: skip to the header, then every payload byte is one
   // word write at BASE+4*i; the frame succeeds when CHK equals the XOR.
   task automatic modelStream(input byteQ_t s, input bit never, output int expDoneN,
                              output bit expErr, output bit expCpu);
      int p = 0;
      int len;
      logic [7:0] x = 8'h00;
      expAdr.delete();
      expDat.delete();
      while (p < s.size() && s[p] != SYNC) p++;
      p++;
      len = (s[p] == 8'h00) ? 256 : int'(s[p]);
      p++;
      if (never) begin
         expDoneN = 0;
         expErr   = 1'b1;
         expCpu   = 1'b1;
         return;
      end
      for (int i = 0; i < len; i++) begin
         x ^= s[p+i];
         expAdr.push_back(BASE + 32'(4 * i));
         expDat.push_back({24'h0, s[p+i]});
      end
      if (s[p+len] == x) begin
         expDoneN = 1;
         expErr   = 1'b0;
         expCpu   = 1'b0;
      end else begin
         expDoneN = 0;
         expErr   = 1'b1;
         expCpu   = 1'b1;
      end
   endtask

   task automatic compareWrites(input string tag);
      int n;
      checkOutput({tag, " write count"}, gotAdr.size(), expAdr.size());
      n = (gotAdr.size() < expAdr.size()) ? gotAdr.size() : expAdr.size();
      for (int i = 0; i < n; i++) begin
         checkOutput($sformatf("%s adr[%0d]", tag, i), gotAdr[i], expAdr[i]);
         checkOutput($sformatf("%s dat[%0d]", tag, i), gotDat[i], expDat[i]);
      end
   endtask

   initial begin
      vector_t vectors [4];
      byteQ_t  stream;
      int      expDoneN;
      bit      expErr;
      bit      expCpu;
      int      nJunk;
      int      len;
      bit      never;
      logic [7:0] b;
      logic [7:0] x;

      vectors[0] = '{bytes: 64'h0000_7744_2211_03A5, nBytes: 4'd6, ackDelay: 4'd1,
                     ackNever: 1'b0, expWrites: 10'd3, expLastAdr: BASE + 32'h8,
                     expLastDat: 32'h44, expDone: 4'd1, expErr: 1'b0, expCpuRst: 1'b0};
      vectors[1] = '{bytes: 64'h0000_0000_0201_02A5, nBytes: 4'd5, ackDelay: 4'd0,
                     ackNever: 1'b0, expWrites: 10'd2, expLastAdr: BASE + 32'h4,
                     expLastDat: 32'h02, expDone: 4'd0, expErr: 1'b1, expCpuRst: 1'b1};
      vectors[2] = '{bytes: 64'h0000_5A5A_01A5_FF00, nBytes: 4'd6, ackDelay: 4'd2,
                     ackNever: 1'b0, expWrites: 10'd1, expLastAdr: BASE,
                     expLastDat: 32'h5A, expDone: 4'd1, expErr: 1'b0, expCpuRst: 1'b0};
      vectors[3] = '{bytes: 64'h0000_0000_0033_01A5, nBytes: 4'd3, ackDelay: 4'd0,
                     ackNever: 1'b1, expWrites: 10'd0, expLastAdr: 32'h0,
                     expLastDat: 32'h0, expDone: 4'd0, expErr: 1'b1, expCpuRst: 1'b1};

      $display("[TB] reset checks");
      repeat (3) @(negedge clock);
      checkOutput("rst s_ready", {31'b0, s_ready_o}, 32'd0);
      checkOutput("rst cyc", {31'b0, wbm_cyc_o}, 32'd0);
      checkOutput("rst stb", {31'b0, wbm_stb_o}, 32'd0);
      checkOutput("rst adr", wbm_adr_o, 32'd0);
      checkOutput("rst busy", {31'b0, busy_o}, 32'd0);
      checkOutput("rst done", {31'b0, done_o}, 32'd0);
      checkOutput("rst err", {31'b0, err_o}, 32'd0);
      checkOutput("rst cpu_reset", {31'b0, cpu_reset_o}, 32'd1);
      resetN = 1'b1;
      @(negedge clock);
      checkOutput("release s_ready", {31'b0, s_ready_o}, 32'd1);

      $display("[TB] vector table");
      for (int v = 0; v < 4; v++) begin
         stream.delete();
         for (int i = 0; i < int'(vectors[v].nBytes); i++)
            stream.push_back(vectors[v].bytes[8*i +: 8]);
         ackDelay = int'(vectors[v].ackDelay);
         ackNever = vectors[v].ackNever;
         clearScoreboard();
         applyStimulus(stream);
         waitIdle(600);
         checkOutput($sformatf("vec%0d writes", v), gotAdr.size(), 32'(vectors[v].expWrites));
         if (vectors[v].expWrites != 0 && gotAdr.size() != 0) begin
            checkOutput($sformatf("vec%0d last adr", v), gotAdr[$], vectors[v].expLastAdr);
            checkOutput($sformatf("vec%0d last dat", v), gotDat[$], vectors[v].expLastDat);
         end
         checkOutput($sformatf("vec%0d done pulses", v), doneCount, 32'(vectors[v].expDone));
         checkOutput($sformatf("vec%0d err", v), {31'b0, err_o}, {31'b0, vectors[v].expErr});
         checkOutput($sformatf("vec%0d cpu_reset", v), {31'b0, cpu_reset_o},
                     {31'b0, vectors[v].expCpuRst});
         if (vectors[v].ackNever)
            checkOutput($sformatf("vec%0d stb cycles", v), lastStbRun, TIMEOUT);
      end
      ackNever = 1'b0;

      $display("[TB] reset during second write");
      clearScoreboard();
      ackDelay = 5;
      sendByte(8'hA5);
      sendByte(8'h03);
      sendByte(8'h11);
      sendByte(8'h22);
      checkOutput("midrst writes before", gotAdr.size(), 32'd1);
      checkOutput("midrst stb before", {31'b0, wbm_stb_o}, 32'd1);
      #2 resetN = 1'b0;
      #1;
      checkOutput("midrst cyc", {31'b0, wbm_cyc_o}, 32'd0);
      checkOutput("midrst stb", {31'b0, wbm_stb_o}, 32'd0);
      checkOutput("midrst cpu_reset", {31'b0, cpu_reset_o}, 32'd1);
      checkOutput("midrst busy", {31'b0, busy_o}, 32'd0);
      @(negedge clock);
      resetN = 1'b1;
      @(negedge clock);
      ackDelay = 1;
      stream = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h44, 8'h77};
      clearScoreboard();
      modelStream(stream, 1'b0, expDoneN, expErr, expCpu);
      applyStimulus(stream);
      waitIdle(600);
      compareWrites("reload");
      checkOutput("reload done", doneCount, 32'd1);
      checkOutput("reload cpu_reset", {31'b0, cpu_reset_o}, 32'd0);

      $display("[TB] 256-byte frame");
      stream.delete();
      stream.push_back(SYNC);
      stream.push_back(8'h00);
      for (int i = 0; i < 256; i++) stream.push_back(8'(i));
      stream.push_back(8'h00);
      ackDelay = 0;
      clearScoreboard();
      modelStream(stream, 1'b0, expDoneN, expErr, expCpu);
      applyStimulus(stream);
      waitIdle(600);
      compareWrites("len256");
      if (gotAdr.size() != 0) begin
         checkOutput("len256 last adr", gotAdr[$], BASE + 32'h3FC);
         checkOutput("len256 last dat", gotDat[$], 32'hFF);
      end
      checkOutput("len256 done", doneCount, 32'd1);
      checkOutput("len256 err", {31'b0, err_o}, 32'd0);

      $display("[TB] random frames");
      ackNoise = 1'b1;
      for (int f = 0; f < 40; f++) begin
         stream.delete();
         nJunk = $urandom_range(0, 2);
         for (int j = 0; j < nJunk; j++) begin
            do b = 8'($urandom); while (b == SYNC);
            stream.push_back(b);
         end
         stream.push_back(SYNC);
         len = $urandom_range(1, 24);
         stream.push_back(8'(len));
         never = ($urandom_range(0, 7) == 0);
         x = 8'h00;
         for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            x ^= b;
            if (!never || i == 0) stream.push_back(b);
         end
         if (!never)
            stream.push_back(($urandom_range(0, 3) == 0) ? (x ^ 8'($urandom_range(1, 255))) : x);
         ackDelay = $urandom_range(0, 3);
         ackNever = never;
         clearScoreboard();
         modelStream(stream, never, expDoneN, expErr, expCpu);
         for (int i = 0; i <= nJunk; i++) sendByte(stream[i]);
         checkOutput($sformatf("rnd%0d busy after sync", f), {31'b0, busy_o}, 32'd1);
         checkOutput($sformatf("rnd%0d cpu_reset after sync", f), {31'b0, cpu_reset_o}, 32'd1);
         checkOutput($sformatf("rnd%0d err after sync", f), {31'b0, err_o}, 32'd0);
         for (int i = nJunk + 1; i < stream.size(); i++) sendByte(stream[i]);
         waitIdle(600);
         compareWrites($sformatf("rnd%0d", f));
         checkOutput($sformatf("rnd%0d done", f), doneCount, expDoneN);
         checkOutput($sformatf("rnd%0d err", f), {31'b0, err_o}, {31'b0, expErr});
         checkOutput($sformatf("rnd%0d cpu_reset", f), {31'b0, cpu_reset_o}, {31'b0, expCpu});
      end
      ackNoise = 1'b0;
      ackNever = 1'b0;

      checkOutput("bus protocol slips", protoErr, 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
